// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle accumulator control unit: opcodes,
// FSM state codes and the A-source / ALU-operation selects.
package cu_pkg;

  localparam int STATE_W = 5;

  localparam logic [3:0] OP_LOAD   = 4'h0;
  localparam logic [3:0] OP_STORE  = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_INPUT  = 4'h4;
  localparam logic [3:0] OP_JZ     = 4'h5;
  localparam logic [3:0] OP_JPOS   = 4'h6;
  localparam logic [3:0] OP_HALT   = 4'h7;
  localparam logic [3:0] OP_AND    = 4'h8;
  localparam logic [3:0] OP_OR     = 4'h9;
  localparam logic [3:0] OP_NOP    = 4'hA;
  localparam logic [3:0] OP_JMP    = 4'hB;
  localparam logic [3:0] OP_JNEG   = 4'hC;
  localparam logic [3:0] OP_OUTPUT = 4'hD;

  typedef enum logic [STATE_W-1:0] {
    S_START   = 5'd0,
    S_FETCH   = 5'd1,
    S_DECODE  = 5'd2,
    S_LOAD    = 5'd3,
    S_STORE   = 5'd4,
    S_ADD     = 5'd5,
    S_SUB     = 5'd6,
    S_INPUT   = 5'd7,
    S_INREL   = 5'd8,
    S_JZ      = 5'd9,
    S_JPOS    = 5'd10,
    S_HALT    = 5'd11,
    S_AND     = 5'd12,
    S_OR      = 5'd13,
    S_JMP     = 5'd14,
    S_JNEG    = 5'd15,
    S_OUTPUT  = 5'd16,
    S_ILLEGAL = 5'd17
  } state_e;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // States that hold for MEM_WAIT+1 cycles under the wait timer.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter: loads MEM_WAIT on entry to a memory state and
// counts down; zero_o marks the last cycle of the access.
module mem_wait_timer #(
  parameter int MEM_WAIT = 0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic load_i,
  output logic zero_o
);

  localparam logic [3:0] MW = 4'(MEM_WAIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = MW;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(negedge Clock or negedge Reset) begin
    if (!Reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for the accumulator processor. Moore outputs from
// state, except PCload in jump states and Aload in INPUT (follow flags/Enter).
module control_unit_mc
  import cu_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int MEM_WAIT = 0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [OPW-1:0]     IR,
  input  logic               Aeq0,
  input  logic               Apos,
  input  logic               Enter,
  output logic               IRload,
  output logic               PCload,
  output logic               JMPmux,
  output logic               Meminst,
  output logic               MemWr,
  output logic               Aload,
  output logic [1:0]         Asel,
  output logic [1:0]         AluOp,
  output logic               Sub,
  output logic               OutLoad,
  output logic               Halt,
  output logic               Illegal,
  output logic [STATE_W-1:0] state
);

  // Widen to at least 4 bits so narrow opcodes zero-extend and wide ones
  // can still be range-checked against the illegal region.
  localparam int OPX = (OPW > 4) ? OPW : 4;

  state_e         state_q, state_d;
  logic [OPX-1:0] opx;
  logic           illegal_op;
  logic           wt_load, wt_zero;

  assign opx        = OPX'(IR);
  assign illegal_op = (opx >= OPX'(14));

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .load_i (wt_load),
    .zero_o (wt_zero)
  );

  always_ff @(negedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_START;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Asel    = ASEL_ALU;
    AluOp   = ALU_ADD;
    OutLoad = 1'b0;
    Halt    = 1'b0;
    Illegal = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (wt_zero) begin
          IRload  = 1'b1;
          PCload  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        Meminst = 1'b1;
        if (illegal_op) state_d = S_ILLEGAL;
        else begin
          case (opx[3:0])
            OP_LOAD:   state_d = S_LOAD;
            OP_STORE:  state_d = S_STORE;
            OP_ADD:    state_d = S_ADD;
            OP_SUB:    state_d = S_SUB;
            OP_INPUT:  state_d = S_INPUT;
            OP_JZ:     state_d = S_JZ;
            OP_JPOS:   state_d = S_JPOS;
            OP_HALT:   state_d = S_HALT;
            OP_AND:    state_d = S_AND;
            OP_OR:     state_d = S_OR;
            OP_JMP:    state_d = S_JMP;
            OP_JNEG:   state_d = S_JNEG;
            OP_OUTPUT: state_d = S_OUTPUT;
            default:   state_d = S_START;
          endcase
        end
      end
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_MEM;
        if (wt_zero) begin
          Aload   = 1'b1;
          state_d = S_START;
        end
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
        if (wt_zero) state_d = S_START;
      end
      S_ADD: begin Aload = 1'b1; AluOp = ALU_ADD; state_d = S_START; end
      S_SUB: begin Aload = 1'b1; AluOp = ALU_SUB; state_d = S_START; end
      S_AND: begin Aload = 1'b1; AluOp = ALU_AND; state_d = S_START; end
      S_OR:  begin Aload = 1'b1; AluOp = ALU_OR;  state_d = S_START; end
      S_INPUT: begin
        Asel = ASEL_IN;
        if (Enter) begin
          Aload   = 1'b1;
          state_d = S_INREL;
        end
      end
      // Hold until the key is released so one press captures once.
      S_INREL: if (!Enter) state_d = S_START;
      S_JZ:   begin JMPmux = 1'b1; PCload = Aeq0;          state_d = S_START; end
      S_JPOS: begin JMPmux = 1'b1; PCload = Apos;          state_d = S_START; end
      S_JNEG: begin JMPmux = 1'b1; PCload = ~Aeq0 & ~Apos; state_d = S_START; end
      S_JMP:  begin JMPmux = 1'b1; PCload = 1'b1;          state_d = S_START; end
      S_OUTPUT: begin OutLoad = 1'b1; state_d = S_START; end
      S_HALT:   Halt = 1'b1;
      S_ILLEGAL: begin Halt = 1'b1; Illegal = 1'b1; end
      default:  state_d = S_START;
    endcase
  end

  assign wt_load = is_mem_state(state_d) && (state_d != state_q);
  assign Sub     = (AluOp == ALU_SUB);
  assign state   = state_q;

endmodule
